// File: rtl/mdr_pkg.sv
// Shared types, encodings and iteration counts for the MDR sequencer and its ALU.
package mdr_pkg;

    localparam int DW_MDR        = 16;
    localparam int D_SHIFT_VALUE = 2 * DW_MDR - 2;
    localparam int CNT_W         = $clog2(DW_MDR) + 1;

    typedef logic [DW_MDR-1:0]   data_bus_n;
    typedef logic [2*DW_MDR-1:0] data_bus_2n;
    typedef logic [2:0]          op_bus;
    typedef logic [CNT_W-1:0]    iter_cnt_t;

    // Encoding 0 is reserved as the idle ALU select, so the ALU outputs zeros.
    localparam op_bus OP_NONE    = 3'd0;
    localparam op_bus MULT       = 3'd1;
    localparam op_bus DIV        = 3'd2;
    localparam op_bus SQRT       = 3'd3;
    localparam op_bus SQRT_FINAL = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    function automatic iter_cnt_t iter_count(input op_bus op_sel);
        return (op_sel == SQRT) ? iter_cnt_t'(DW_MDR / 2) : iter_cnt_t'(DW_MDR);
    endfunction

    function automatic logic op_legal(input op_bus op_sel);
        return (op_sel == MULT) || (op_sel == DIV) || (op_sel == SQRT);
    endfunction

endpackage

// File: rtl/mdr_if.sv
// Operand/select bus from the sequencer to the combinational ALU and its results back.
interface mdr_alu_if;
    import mdr_pkg::*;

    data_bus_n  alu_value_x;
    data_bus_2n alu_value_d;
    data_bus_n  alu_operator_a;
    data_bus_n  alu_operator_b;
    op_bus      alu_select;
    data_bus_n  alu_add;
    data_bus_n  alu_sub;

    modport master (
        output alu_value_x, alu_value_d, alu_operator_a, alu_operator_b, alu_select,
        input  alu_add, alu_sub
    );

    modport slave (
        input  alu_value_x, alu_value_d, alu_operator_a, alu_operator_b, alu_select,
        output alu_add, alu_sub
    );

endinterface

// File: rtl/mdr_alu.sv
// Purely combinational add/sub unit shared by MULT, DIV and SQRT steps.
module alu
    import mdr_pkg::*;
(
    input  data_bus_n  in_value_x,
    input  data_bus_2n in_value_d,
    input  data_bus_n  in_operator_a,
    input  data_bus_n  in_operator_b,
    input  op_bus      in_alu_select,
    output data_bus_n  add,
    output data_bus_n  sub
);

    logic [1:0] d_top;
    data_bus_n  sq_t;
    data_bus_n  sq_trial;
    logic       unused_bits;

    // SQRT brings down the next radicand bit pair from the top of value_d.
    assign d_top       = in_value_d[D_SHIFT_VALUE +: 2];
    assign sq_t        = {in_operator_a[DW_MDR-3:0], d_top};
    assign sq_trial    = {in_operator_b[DW_MDR-3:0], 2'b01};
    assign unused_bits = ^{in_value_d[D_SHIFT_VALUE-1:0], in_operator_b[DW_MDR-1:DW_MDR-2]};

    always_comb begin
        add = '0;
        sub = '0;
        case (in_alu_select)
            MULT, DIV: begin
                add = in_operator_a + in_value_x;
                sub = in_operator_a - in_value_x;
            end
            SQRT: begin
                add = sq_t;
                sub = sq_t - sq_trial;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdr_sequencer.sv
// Iterative MULT/DIV/SQRT controller: owns all state and steps the external ALU once per cycle.
module mdr_sequencer
    import mdr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  op_bus      op,
    input  data_bus_n  operand_a,
    input  data_bus_n  operand_b,
    output logic       ready,
    output logic       busy,
    output logic       result_valid,
    output logic       error,
    output data_bus_n  result_lo,
    output data_bus_n  result_hi,
    output seq_state_e dbg_state,
    mdr_alu_if.master  alu_bus
);

    // Handshake: start is taken only on a cycle with ready=1; result_valid is a
    // single-cycle pulse with no backpressure, results and error hold until the next accept.

    seq_state_e state, state_nx;
    iter_cnt_t  cnt;
    op_bus      op_r;
    data_bus_n  acc, q, x;
    data_bus_2n d;
    data_bus_n  acc_nx, q_nx;
    data_bus_2n d_nx;

    logic      accept, accept_err, last;
    logic      mult_carry, div_take, sq_take;
    data_bus_n div_t, sq_trial;

    assign accept     = (state == IDLE) && start;
    assign accept_err = !op_legal(op) || ((op == DIV) && (operand_b == '0));
    assign last       = (cnt == (iter_count(op_r) - iter_cnt_t'(1)));
    assign dbg_state  = state;

    // acc/q double as r/q for DIV and rem/root for SQRT.
    assign mult_carry = alu_bus.alu_add < acc;
    assign div_t      = {acc[DW_MDR-2:0], q[DW_MDR-1]};
    assign div_take   = acc[DW_MDR-1] || (div_t >= x);
    assign sq_trial   = {q[DW_MDR-3:0], 2'b01};
    assign sq_take    = alu_bus.alu_add >= sq_trial;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = accept_err ? DONE : ITER;
            ITER:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready                  = (state == IDLE);
        busy                   = (state == ITER) || (state == DONE);
        result_valid           = (state == DONE);
        alu_bus.alu_value_x    = '0;
        alu_bus.alu_value_d    = '0;
        alu_bus.alu_operator_a = '0;
        alu_bus.alu_operator_b = '0;
        alu_bus.alu_select     = OP_NONE;
        if (state == ITER) begin
            alu_bus.alu_select = op_r;
            case (op_r)
                MULT: begin
                    alu_bus.alu_operator_a = acc;
                    alu_bus.alu_value_x    = x;
                end
                DIV: begin
                    alu_bus.alu_operator_a = div_t;
                    alu_bus.alu_value_x    = x;
                end
                SQRT: begin
                    alu_bus.alu_operator_a = acc;
                    alu_bus.alu_operator_b = q;
                    alu_bus.alu_value_d    = d;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        acc_nx = acc;
        q_nx   = q;
        d_nx   = d;
        case (op_r)
            MULT: begin
                if (q[0]) begin
                    acc_nx = {mult_carry, alu_bus.alu_add[DW_MDR-1:1]};
                    q_nx   = {alu_bus.alu_add[0], q[DW_MDR-1:1]};
                end else begin
                    acc_nx = {1'b0, acc[DW_MDR-1:1]};
                    q_nx   = {acc[0], q[DW_MDR-1:1]};
                end
            end
            DIV: begin
                acc_nx = div_take ? alu_bus.alu_sub : div_t;
                q_nx   = {q[DW_MDR-2:0], div_take};
            end
            SQRT: begin
                acc_nx = sq_take ? alu_bus.alu_sub : alu_bus.alu_add;
                q_nx   = {q[DW_MDR-2:0], sq_take};
                d_nx   = {d[2*DW_MDR-3:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_r      <= OP_NONE;
            acc       <= '0;
            q         <= '0;
            x         <= '0;
            d         <= '0;
            error     <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else if (accept) begin
            cnt  <= '0;
            op_r <= op;
            acc  <= '0;
            d    <= '0;
            if (accept_err) begin
                error     <= 1'b1;
                result_lo <= '1;
                result_hi <= operand_a;
            end else begin
                error <= 1'b0;
                case (op)
                    MULT: begin q <= operand_b; x <= operand_a; end
                    DIV:  begin q <= operand_a; x <= operand_b; end
                    default: begin
                        q <= '0;
                        d <= {operand_a, {DW_MDR{1'b0}}};
                    end
                endcase
            end
        end else if (state == ITER) begin
            acc <= acc_nx;
            q   <= q_nx;
            d   <= d_nx;
            cnt <= cnt + iter_cnt_t'(1);
            if (last) begin
                result_lo <= q_nx;
                result_hi <= acc_nx;
            end
        end
    end

endmodule

// File: tb/tb_mdr_sequencer.sv
// Directed bench for mdr_sequencer driving the combinational alu through mdr_alu_if.
module tb_mdr_sequencer;
    import mdr_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    op_bus      op;
    data_bus_n  operand_a, operand_b;
    logic       ready, busy, result_valid, error;
    data_bus_n  result_lo, result_hi;
    seq_state_e dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    mdr_alu_if alu_bus ();

    mdr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .error        (error),
        .result_lo    (result_lo),
        .result_hi    (result_hi),
        .dbg_state    (dbg_state),
        .alu_bus      (alu_bus)
    );

    alu u_alu (
        .in_value_x    (alu_bus.alu_value_x),
        .in_value_d    (alu_bus.alu_value_d),
        .in_operator_a (alu_bus.alu_operator_a),
        .in_operator_b (alu_bus.alu_operator_b),
        .in_alu_select (alu_bus.alu_select),
        .add           (alu_bus.alu_add),
        .sub           (alu_bus.alu_sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latency counts negedge samples after the accepting edge; -1 means no result within budget.
    task automatic run_op(input op_bus o, input data_bus_n a, input data_bus_n b,
                          output int lat, output data_bus_n lo, output data_bus_n hi, output logic err);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (result_valid) begin lat = i; break; end
        end
        lo = result_lo; hi = result_hi; err = error;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b want=1", ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        tests_run++; if ({error, result_lo, result_hi} !== 33'd0) begin tests_failed++; $display("FAIL reset_results got=%b/%h/%h want=0/0000/0000", error, result_lo, result_hi); end
        tests_run++; if (alu_bus.alu_select !== OP_NONE) begin tests_failed++; $display("FAIL reset_alu_select got=%0d want=0", alu_bus.alu_select); end
        tests_run++; if ({alu_bus.alu_add, alu_bus.alu_sub} !== 32'd0) begin tests_failed++; $display("FAIL reset_alu_out got=%h/%h want=0/0", alu_bus.alu_add, alu_bus.alu_sub); end
        tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
        rst = 1'b1;
    endtask

    task automatic test_mult();
        int lat; data_bus_n lo, hi; logic err;
        run_op(MULT, 16'd300, 16'd200, lat, lo, hi, err);
        tests_run++; if (lat !== 17) begin tests_failed++; $display("FAIL mult_small_latency got=%0d want=17", lat); end
        tests_run++; if (lo !== 16'hEA60 || hi !== 16'h0000 || err !== 1'b0) begin tests_failed++; $display("FAIL mult_small_result got=%h/%h/%b want=ea60/0000/0", lo, hi, err); end
        @(negedge clk);
        tests_run++; if (result_valid !== 1'b0 || ready !== 1'b1) begin tests_failed++; $display("FAIL mult_pulse_end got valid=%b ready=%b want 0/1", result_valid, ready); end
        tests_run++; if (result_lo !== 16'hEA60) begin tests_failed++; $display("FAIL mult_hold_lo got=%h want=ea60", result_lo); end
        run_op(MULT, 16'hFFFF, 16'hFFFF, lat, lo, hi, err);
        tests_run++; if (lo !== 16'h0001 || hi !== 16'hFFFE || err !== 1'b0 || lat !== 17) begin tests_failed++; $display("FAIL mult_carry got=%h/%h/%b lat=%0d want=0001/fffe/0 lat=17", lo, hi, err, lat); end
    endtask

    task automatic test_div();
        int lat; data_bus_n lo, hi; logic err;
        run_op(DIV, 16'd1000, 16'd7, lat, lo, hi, err);
        tests_run++; if (lat !== 17) begin tests_failed++; $display("FAIL div_latency got=%0d want=17", lat); end
        tests_run++; if (lo !== 16'd142 || hi !== 16'd6 || err !== 1'b0) begin tests_failed++; $display("FAIL div_1000_7 got=%0d/%0d/%b want=142/6/0", lo, hi, err); end
        run_op(DIV, 16'hFFFF, 16'h8001, lat, lo, hi, err);
        tests_run++; if (lo !== 16'h0001 || hi !== 16'h7FFE || err !== 1'b0) begin tests_failed++; $display("FAIL div_msb got=%h/%h/%b want=0001/7ffe/0", lo, hi, err); end
    endtask

    task automatic test_errors();
        int lat; data_bus_n lo, hi; logic err;
        run_op(DIV, 16'd1234, 16'd0, lat, lo, hi, err);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL div0_latency got=%0d want=1", lat); end
        tests_run++; if (lo !== 16'hFFFF || hi !== 16'd1234 || err !== 1'b1) begin tests_failed++; $display("FAIL div0_result got=%h/%0d/%b want=ffff/1234/1", lo, hi, err); end
        @(negedge clk);
        tests_run++; if (error !== 1'b1 || result_valid !== 1'b0) begin tests_failed++; $display("FAIL div0_hold got err=%b valid=%b want 1/0", error, result_valid); end
        run_op(SQRT_FINAL, 16'h55AA, 16'd3, lat, lo, hi, err);
        tests_run++; if (lat !== 1 || lo !== 16'hFFFF || hi !== 16'h55AA || err !== 1'b1) begin tests_failed++; $display("FAIL illegal_op got=%h/%h/%b lat=%0d want=ffff/55aa/1 lat=1", lo, hi, err, lat); end
    endtask

    task automatic test_sqrt();
        int lat; data_bus_n lo, hi; logic err;
        run_op(SQRT, 16'd1000, 16'd0, lat, lo, hi, err);
        tests_run++; if (lat !== 9) begin tests_failed++; $display("FAIL sqrt_latency got=%0d want=9", lat); end
        tests_run++; if (lo !== 16'd31 || hi !== 16'd39 || err !== 1'b0) begin tests_failed++; $display("FAIL sqrt_1000 got=%0d/%0d/%b want=31/39/0", lo, hi, err); end
        run_op(SQRT, 16'hFFFF, 16'h1234, lat, lo, hi, err);
        tests_run++; if (lo !== 16'd255 || hi !== 16'd510 || err !== 1'b0) begin tests_failed++; $display("FAIL sqrt_max got=%0d/%0d/%b want=255/510/0", lo, hi, err); end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        start = 1'b1; op = MULT; operand_a = 16'd300; operand_b = 16'd200;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 4) begin start = 1'b1; op = DIV; operand_a = 16'd1000; operand_b = 16'd7; end
            else start = 1'b0;
            if (result_valid) begin lat = i; break; end
        end
        start = 1'b0;
        tests_run++; if (lat !== 17 || result_lo !== 16'hEA60 || result_hi !== 16'h0000) begin tests_failed++; $display("FAIL busy_start got=%h/%h lat=%0d want=ea60/0000 lat=17", result_lo, result_hi, lat); end
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || ready !== 1'b1) begin tests_failed++; $display("FAIL busy_start_queued got busy=%b ready=%b want 0/1", busy, ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat; int valid_seen; data_bus_n lo, hi; logic err;
        @(negedge clk);
        start = 1'b1; op = MULT; operand_a = 16'h1234; operand_b = 16'h5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy got=%b want=1", busy); end
        rst = 1'b0;
        #1;
        tests_run++; if (ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got ready=%b busy=%b valid=%b want 1/0/0", ready, busy, result_valid); end
        tests_run++; if (result_lo !== 16'd0 || result_hi !== 16'd0 || alu_bus.alu_select !== OP_NONE || alu_bus.alu_operator_a !== 16'd0) begin tests_failed++; $display("FAIL midrst_outputs got lo=%h hi=%h sel=%0d opa=%h want 0/0/0/0", result_lo, result_hi, alu_bus.alu_select, alu_bus.alu_operator_a); end
        @(negedge clk);
        rst = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) valid_seen++;
        end
        tests_run++; if (valid_seen !== 0) begin tests_failed++; $display("FAIL midrst_no_valid got=%0d want=0", valid_seen); end
        run_op(DIV, 16'd1000, 16'd7, lat, lo, hi, err);
        tests_run++; if (lat !== 17 || lo !== 16'd142 || hi !== 16'd6 || err !== 1'b0) begin tests_failed++; $display("FAIL midrst_recover got=%0d/%0d/%b lat=%0d want=142/6/0 lat=17", lo, hi, err, lat); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = OP_NONE; operand_a = '0; operand_b = '0;
        test_reset();
        test_mult();
        test_div();
        test_errors();
        test_sqrt();
        test_start_ignored();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Iterative control/datapath front-end of the MDR unit.
- Accepts an operation request and drives the ALU operand/select inputs every cycle.
- Consumes the ALU `add`/`sub` results back into its own state registers, then presents the final result with a valid pulse.
- This is the ALU's producer/consumer counterpart: it owns all state; the ALU stays purely combinational.

Parameters:
DW_MDR, 16, operand width N (from mdr_pkg; must be even, ≥4)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  request; sampled only when ready=1
op  in  op_bus  MULT, DIV or SQRT
operand_a  in  N  multiplicand / dividend / radicand
operand_b  in  N  multiplier / divisor (ignored for SQRT)
ready  out  1  high in IDLE only
busy  out  1  high in ITER and DONE
result_valid  out  1  one-cycle pulse in DONE
error  out  1  div-by-zero or illegal op; valid with result_valid, held until next accept
result_lo  out  N  product[N-1:0] / quotient / root
result_hi  out  N  product[2N-1:N] / remainder / sqrt remainder
alu_value_x  out  N  to ALU in_value_x
alu_value_d  out  2N  to ALU in_value_d
alu_operator_a  out  N  to ALU in_operator_a
alu_operator_b  out  N  to ALU in_operator_b
alu_select  out  op_bus  to ALU in_alu_select
alu_add  in  N  from ALU add
alu_sub  in  N  from ALU sub

Behaviour:
- Reset (async, rst=0): state=IDLE; every register and output 0, except ready=1; alu_select=default (ALU drives zeros). Reset mid-ITER aborts with no result_valid.
- FSM IDLE -> ITER -> DONE -> IDLE.
- Accept: IDLE & start sets iteration counter to 0 and latches op, operands and per-op init:
  - MULT: acc=0, q=operand_b, x=operand_a.
  - DIV: r=0, q=operand_a, x=operand_b.
  - SQRT: rem=0, root=0, d={operand_a, N'0}.
- Accept with DIV and operand_b=0, or with an op outside {MULT, DIV, SQRT}: go directly to DONE with error=1, result_lo all-ones, result_hi=operand_a.
- start while busy is ignored; ops are never queued.
- ITER, one step per cycle, ALU outputs combinationally consumed in the same cycle:
  - MULT: operator_a=acc, value_x=x. carry = (alu_add < acc). If q[0], {acc,q} <= {carry,alu_add,q}>>1; else {acc,q} <= {1'b0,acc,q}>>1. N iterations.
  - DIV (restoring): t={r[N-2:0],q[N-1]}, msb=r[N-1]; operator_a=t, value_x=x. If msb | (t>=x): r<=alu_sub, q<={q[N-2:0],1}; else r<=t, q<={q[N-2:0],0}. N iterations.
  - SQRT: operator_a=rem, operator_b=root, value_d=d. The ALU forms T=(rem<<2)|d[2N-1:2N-2] and sub=T-((root<<2)|1). If T >= (root<<2)|1: rem<=alu_sub, root<={root,1}; else rem<=alu_add (T), root<={root,0}. d<=d<<2. N/2 iterations. SQRT_FINAL is never driven.
- Leaving ITER: after the last iteration, results are registered and the FSM enters DONE.
- Latency: result_valid is high exactly ITERS+1 cycles after the accepting edge (MULT/DIV: N+1; SQRT: N/2+1; error path: 1).
- DONE: result_valid=1 for one cycle, then IDLE.
- result_lo/result_hi/error hold until the next accept.
- All arithmetic is unsigned; ALU results are modulo 2^N, and the carry/msb terms above recover the lost bit.

Decomposition:
- mdr_pkg: DW_MDR, data_bus_n, data_bus_2n, op_bus with MULT/DIV/SQRT/SQRT_FINAL encodings, D_SHIFT_VALUE = 2*DW_MDR-2, and a new seq_state_e enum (IDLE, ITER, DONE). Iteration counts go in as package functions.
- Sub-module: none required.
- Top-level mdr_top instantiates mdr_sequencer and alu.
- The bench instantiates both together.

Test Plan (DW_MDR=16):
- MULT 300×200 -> result_valid at cycle 17 after accept; lo=0xEA60, hi=0x0000, error=0.
- MULT 0xFFFF×0xFFFF -> lo=0x0001, hi=0xFFFE (carry path).
- DIV 1000/7 -> lo=142, hi=6. DIV 0xFFFF/0x8001 -> lo=1, hi=0x7FFE (msb path).
- DIV 1234/0 -> valid 1 cycle after accept; error=1, lo=0xFFFF, hi=1234.
- SQRT 1000 -> valid 9 cycles after accept; lo=31, hi=39. SQRT 0xFFFF -> lo=255, hi=510.
- Start pulsed during ITER is ignored. rst dropped mid-MULT -> outputs 0 and ready=1 immediately; no valid pulse. A new op after reset completes correctly.
